// File: rtl/riscv_fetch_queue_pkg.sv
// riscv_fetch_queue_pkg
//   Shared definitions for the RISCV150 fetch queue: instruction width, the
//   canonical NOP (addi x0, x0, 0) driven while no instruction is presented,
//   and the width helper for the queue occupancy counter.
package riscv_fetch_queue_pkg;

    localparam int INST_WIDTH = 32;
    localparam logic [INST_WIDTH-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/riscv_fetch_queue_if.sv
// riscv_fetch_queue_if
//   Bundles the fetch stage's control inputs, IMEM request/response and the
//   decode-side valid/ready handshake.
//   master : the fetch queue (drives imem_re/imem_addr and the head outputs)
//   slave  : the surroundings (pipeline control, IMEM, decode)
//   Signals: stall, redirect_valid, redirect_pc, imem_re, imem_addr, imem_dout,
//            inst_valid, deq_ready, inst, inst_pc, inst_pc_plus4, count
interface riscv_fetch_queue_if
    import riscv_fetch_queue_pkg::*;
#(
    parameter int PC_WIDTH = 14,
    parameter int DEPTH    = 4
);
    logic                        stall;
    logic                        redirect_valid;
    logic [PC_WIDTH-1:0]         redirect_pc;
    logic                        imem_re;
    logic [PC_WIDTH-3:0]         imem_addr;
    logic [INST_WIDTH-1:0]       imem_dout;
    logic                        inst_valid;
    logic                        deq_ready;
    logic [INST_WIDTH-1:0]       inst;
    logic [PC_WIDTH-1:0]         inst_pc;
    logic [PC_WIDTH-1:0]         inst_pc_plus4;
    logic [cnt_width(DEPTH)-1:0] count;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_dout, deq_ready,
        output imem_re, imem_addr, inst_valid, inst, inst_pc, inst_pc_plus4, count
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_dout, deq_ready,
        input  imem_re, imem_addr, inst_valid, inst, inst_pc, inst_pc_plus4, count
    );
endinterface

// File: rtl/riscv_fetch_queue_fetch_fifo.sv
// fetch_fifo
//   Synchronous FIFO holding {instruction, pc} entries for the fetch queue.
//   Ports: clk, rst (sync, active-high), clr (flush, priority over wr/rd),
//          wr_en/wr_data, rd_en, rd_data (current head), count (occupancy).
//   Reads of an empty FIFO and writes to a full FIFO (without a read) are ignored.
module fetch_fifo #(
    parameter int WIDTH = 46,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_rd = rd_en && (count != '0);
    assign do_wr = wr_en && ((count != FULL) || do_rd);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; count and the
    // pointers decide which words are meaningful, so the data can map to RAM.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

    // Upstream credit accounting must never push into a full queue.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst || clr)
        !(wr_en && (count == FULL) && !rd_en));

endmodule

// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue
//   RISCV150 fetch stage: owns the PC, issues reads to a fixed-latency IMEM,
//   buffers the returned words in a DEPTH-entry queue and presents the head to
//   decode with valid/ready. A redirect flushes the queue and flips the epoch so
//   reads already in flight are discarded when they return.
//   Ports: clk, rst (sync, active-high), bus (riscv_fetch_queue_if.master).
module riscv_fetch_queue
    import riscv_fetch_queue_pkg::*;
#(
    parameter int                    PC_WIDTH     = 14,
    parameter int                    DEPTH        = 4,
    parameter int                    IMEM_LATENCY = 1,
    parameter logic [PC_WIDTH-1:0]   RESET_PC     = '0,
    parameter logic [INST_WIDTH-1:0] NOP_INST     = NOP_INST_DEFAULT
) (
    input logic                 clk,
    input logic                 rst,
    riscv_fetch_queue_if.master bus
);
    localparam int CW    = cnt_width(DEPTH);
    localparam int SUM_W = CW + 2;
    localparam int LAST  = IMEM_LATENCY - 1;

    typedef struct packed {
        logic                valid;
        logic                epoch;
        logic [PC_WIDTH-1:0] pc;
    } tag_t;

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [PC_WIDTH-1:0]   pc;
    } entry_t;

    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] redirect_target;
    logic                epoch;
    tag_t                tags [IMEM_LATENCY];
    logic [SUM_W-1:0]    inflight;
    logic [CW-1:0]       fifo_count;
    logic                issue;
    logic                resp_ok;
    logic                fire;
    logic                head_valid;
    entry_t              wr_entry;
    entry_t              head;

    // NOTE: every variable assigned in always_comb gets a value before any
    // conditional logic, so no path can leave it holding state (no latch).
    always_comb begin
        inflight = '0;
        for (int i = 0; i < IMEM_LATENCY; i++) begin
            inflight = inflight + SUM_W'(tags[i].valid);
        end
    end

    // Queued plus in-flight reads never exceed DEPTH, so every response that
    // comes back has a free slot waiting for it.
    assign issue = !rst && !bus.stall && !bus.redirect_valid &&
                   ((SUM_W'(fifo_count) + inflight) < SUM_W'(DEPTH));

    assign redirect_target = bus.redirect_pc & ~PC_WIDTH'(3);

    // A response from an older epoch, or one landing on a redirect cycle, is
    // stale. A single epoch bit is sufficient while redirects are at least
    // IMEM_LATENCY-1 cycles apart or IMEM_LATENCY <= 2.
    assign resp_ok = tags[LAST].valid && (tags[LAST].epoch == epoch) && !bus.redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            epoch    <= 1'b0;
            for (int i = 0; i < IMEM_LATENCY; i++) tags[i] <= '0;
        end else begin
            if (bus.redirect_valid) begin
                fetch_pc <= redirect_target;
                epoch    <= ~epoch;
            end else if (issue) begin
                fetch_pc <= fetch_pc + PC_WIDTH'(4);
            end
            // Tracking pipe mirrors the IMEM pipeline and advances even on stall.
            tags[0] <= '{valid: issue, epoch: epoch, pc: fetch_pc};
            for (int i = 1; i < IMEM_LATENCY; i++) tags[i] <= tags[i-1];
        end
    end

    assign wr_entry = '{inst: bus.imem_dout, pc: tags[LAST].pc};

    fetch_fifo #(
        .WIDTH (INST_WIDTH + PC_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (bus.redirect_valid),
        .wr_en   (resp_ok),
        .wr_data (wr_entry),
        .rd_en   (fire),
        .rd_data (head),
        .count   (fifo_count)
    );

    assign head_valid = (fifo_count != '0);

    // The head stays visible on a redirect cycle but is not consumed.
    assign bus.inst_valid    = head_valid && !bus.stall && !rst;
    assign fire              = bus.inst_valid && bus.deq_ready && !bus.redirect_valid;
    assign bus.inst          = bus.inst_valid ? head.inst : NOP_INST;
    assign bus.inst_pc       = bus.inst_valid ? head.pc : '0;
    assign bus.inst_pc_plus4 = bus.inst_valid ? head.pc + PC_WIDTH'(4) : '0;
    assign bus.count         = fifo_count;
    assign bus.imem_re       = issue;
    assign bus.imem_addr     = fetch_pc[PC_WIDTH-1:2];

    // Decode must hold a redirect until the global stall drops.
    a_no_redirect_on_stall: assert property (@(posedge clk) disable iff (rst)
        !(bus.redirect_valid && bus.stall));

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// tb_riscv_fetch_queue
//   Drives the fetch queue with directed scenarios followed by random stall,
//   backpressure, redirect and reset traffic. The reference model tracks the
//   program-order stream that decode must see: the next expected PC starts at
//   the reset or redirect target and steps by 4 per accepted instruction, and
//   every instruction word equals the IMEM content at that PC.
module tb_riscv_fetch_queue;
    localparam int          PC_W   = 14;
    localparam int          DEPTH  = 4;
    localparam int          LAT    = 2;
    localparam logic [13:0] RST_PC = 14'h3FF8;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;

    riscv_fetch_queue_if #(.PC_WIDTH(PC_W), .DEPTH(DEPTH)) bus();

    riscv_fetch_queue #(
        .PC_WIDTH     (PC_W),
        .DEPTH        (DEPTH),
        .IMEM_LATENCY (LAT),
        .RESET_PC     (RST_PC),
        .NOP_INST     (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // IMEM model: content is a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [PC_W-3:0] a);
        return 32'hA500_0000 ^ ({20'd0, a} * 32'h9E37_79B1);
    endfunction

    logic [31:0] rd_pipe [LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= bus.imem_re ? mem_word(bus.imem_addr) : $urandom;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.imem_dout = rd_pipe[LAT-1];

    int          checks = 0;
    int          errors = 0;
    int          n_fire = 0;
    logic        expect_stream = 1'b0;
    logic [13:0] exp_pc;
    logic [13:0] exp_fetch;
    logic [13:0] fired_pcs [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called once per cycle, after inputs settle and before the rising edge.
    task automatic monitor();
        logic [13:0] p4;
        if (!bus.inst_valid) check("nop_idle", bus.inst, NOP);
        if (bus.stall) check("stall_hides", bus.inst_valid, 1'b0);
        if (rst || bus.stall || bus.redirect_valid) check("no_issue", bus.imem_re, 1'b0);
        check("count_max", bus.count <= DEPTH, 1'b1);
        if (expect_stream) check("stream", bus.inst_valid, 1'b1);
        if (rst) begin
            exp_pc    = RST_PC;
            exp_fetch = RST_PC;
            return;
        end
        if (bus.inst_valid) begin
            p4 = bus.inst_pc + 14'd4;
            check("pc_plus4", bus.inst_pc_plus4, p4);
        end
        if (bus.redirect_valid) begin
            exp_pc    = bus.redirect_pc & ~14'd3;
            exp_fetch = bus.redirect_pc & ~14'd3;
        end else begin
            if (bus.inst_valid && bus.deq_ready) begin
                check("inst_pc", bus.inst_pc, exp_pc);
                check("inst_data", bus.inst, mem_word(exp_pc[13:2]));
                fired_pcs.push_back(bus.inst_pc);
                exp_pc = exp_pc + 14'd4;
                n_fire++;
            end
            if (bus.imem_re) begin
                check("imem_addr", bus.imem_addr, exp_fetch[13:2]);
                exp_fetch = exp_fetch + 14'd4;
            end
        end
    endtask

    task automatic step();
        #1;
        monitor();
        @(negedge clk);
    endtask

    // Counts cycles with inst_valid low; leaves time at negedge+1 of the valid cycle.
    task automatic wait_valid(output int n, input int limit);
        n = 0;
        #1;
        while (!bus.inst_valid && n < limit) begin
            monitor();
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int fire_base;
        rst                = 1'b1;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.deq_ready      = 1'b1;
        exp_pc             = RST_PC;
        exp_fetch          = RST_PC;
        @(negedge clk);
        step();
        step();

        // Reset state.
        #1;
        check("rst_count", bus.count, 0);
        check("rst_valid", bus.inst_valid, 1'b0);
        check("rst_inst", bus.inst, NOP);
        check("rst_pc", bus.inst_pc, 0);
        check("rst_re", bus.imem_re, 1'b0);

        // Release: first instruction after LAT+1 cycles, then one per cycle,
        // crossing the top of the address space.
        rst = 1'b0;
        wait_valid(n, 20);
        check("first_latency", n, LAT + 1);
        check("first_pc", bus.inst_pc, RST_PC);
        expect_stream = 1'b1;
        repeat (12) step();
        expect_stream = 1'b0;
        check("wrap_pc0", fired_pcs[0], 14'h3FF8);
        check("wrap_pc1", fired_pcs[1], 14'h3FFC);
        check("wrap_pc2", fired_pcs[2], 14'h0000);

        // Backpressure: queue fills, issue stops, nothing is lost.
        bus.deq_ready = 1'b0;
        repeat (10) step();
        #1;
        check("bp_count", bus.count, DEPTH);
        check("bp_re", bus.imem_re, 1'b0);
        bus.deq_ready = 1'b1;
        repeat (10) step();

        // Redirect with reads in flight.
        #1;
        check("redir_head_shown", bus.inst_valid, 1'b1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 14'h0123;
        step();
        bus.redirect_valid = 1'b0;
        wait_valid(n, 20);
        check("redir_gap", n, LAT + 1);
        check("redir_pc", bus.inst_pc, 14'h0120);
        repeat (8) step();

        // Back-to-back redirects: last target wins.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 14'h0200;
        step();
        bus.redirect_pc    = 14'h0407;
        step();
        bus.redirect_valid = 1'b0;
        wait_valid(n, 20);
        check("b2b_pc", bus.inst_pc, 14'h0404);
        repeat (8) step();

        // Stall with reads in flight: responses are captured, nothing shown.
        bus.stall = 1'b1;
        repeat (5) step();
        #1;
        check("stall_capture", bus.count, 3);
        bus.stall = 1'b0;
        repeat (8) step();

        // Reset with a partly full queue and reads in flight.
        bus.deq_ready = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst           = 1'b0;
        bus.deq_ready = 1'b1;
        #1;
        check("rst2_count", bus.count, 0);
        check("rst2_valid", bus.inst_valid, 1'b0);
        check("rst2_re", bus.imem_re, 1'b1);
        check("rst2_addr", bus.imem_addr, RST_PC >> 2);
        repeat (8) step();

        // Random traffic.
        fire_base = n_fire;
        for (int c = 0; c < 3000; c++) begin
            rst                = ($urandom_range(399) == 0);
            bus.stall          = ($urandom_range(4) == 0);
            bus.deq_ready      = ($urandom_range(9) < 7);
            bus.redirect_valid = !bus.stall && ($urandom_range(19) == 0);
            bus.redirect_pc    = 14'($urandom);
            step();
        end
        check("random_progress", (n_fire - fire_base) > 300, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
